// File: rtl/dadda_multiplier_pipelined.sv
// Pipelined WIDTH x WIDTH Dadda multiplier, unsigned or Baugh-Wooley signed per transaction.
// S1 holds operands, S2 the two reduced rows, S3 the Kogge-Stone sum; one elastic stall signal.
module dadda_multiplier_pipelined #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic               signed_mode,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               out_valid,
  input  logic               out_ready
);
  localparam int PW     = 2 * WIDTH;
  localparam int MAXH   = WIDTH + 1;
  localparam int STAGES = 3;
  localparam int NSEQ   = 8;
  localparam int LVLS   = $clog2(PW);

  // k-th Dadda height limit: 2,3,4,6,9,13,19,28
  function automatic int dadda_d(input int k);
    int d;
    d = 2;
    for (int i = 0; i < k; i++) d = (d * 3) / 2;
    return d;
  endfunction

  function automatic logic [PW-1:0] KSA_nbits(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [LVLS:0][PW-1:0] g, p;
    g[0] = a & b;
    p[0] = a ^ b;
    for (int l = 0; l < LVLS; l++) begin
      for (int i = 0; i < PW; i++) begin
        if (i >= (1 << l)) begin
          g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
          p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
        end else begin
          g[l+1][i] = g[l][i];
          p[l+1][i] = p[l][i];
        end
      end
    end
    return p[0] ^ {g[LVLS][PW-2:0], 1'b0};
  endfunction

  logic [STAGES:1]  vld_pipe;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic             s1_sgn;
  logic [PW-1:0]    s2_row0, s2_row1;
  logic [PW-1:0]    row0, row1;
  logic             advance;

  assign advance   = !vld_pipe[STAGES] | out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[STAGES];

  // Column heaps are tracked with elaboration-constant heights, so the loops unroll into a fixed adder tree.
  always_comb begin
    logic heap [PW][MAXH];
    logic nxt  [PW][MAXH];
    int   hgt  [PW];
    int   nh   [PW];
    int   k, rem, lim;
    k = 0; rem = 0; lim = 0;
    for (int c = 0; c < PW; c++) begin
      hgt[c] = 0;
      nh[c]  = 0;
      for (int r = 0; r < MAXH; r++) begin
        heap[c][r] = 1'b0;
        nxt[c][r]  = 1'b0;
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        heap[i+j][hgt[i+j]] = (s1_a[j] & s1_b[i]) ^ (s1_sgn & ((i == WIDTH-1) != (j == WIDTH-1)));
        hgt[i+j]++;
      end
    end
    heap[WIDTH][hgt[WIDTH]] = s1_sgn;
    hgt[WIDTH]++;
    heap[PW-1][hgt[PW-1]] = s1_sgn;
    hgt[PW-1]++;

    for (int s = NSEQ-1; s >= 0; s--) begin
      lim = dadda_d(s);
      if (lim < WIDTH) begin
        for (int c = 0; c < PW; c++) begin
          nh[c] = 0;
          for (int r = 0; r < MAXH; r++) nxt[c][r] = 1'b0;
        end
        for (int c = 0; c < PW; c++) begin
          k = 0;
          for (int t = 0; t < MAXH; t++) begin
            rem = hgt[c] - k + nh[c];
            if (rem > lim && rem - lim >= 2 && hgt[c] - k >= 3) begin
              nxt[c][nh[c]] = heap[c][k] ^ heap[c][k+1] ^ heap[c][k+2];
              nh[c]++;
              if (c + 1 < PW) begin
                nxt[c+1][nh[c+1]] = (heap[c][k] & heap[c][k+1]) | (heap[c][k+2] & (heap[c][k] ^ heap[c][k+1]));
                nh[c+1]++;
              end
              k += 3;
            end else if (rem > lim && hgt[c] - k >= 2) begin
              nxt[c][nh[c]] = heap[c][k] ^ heap[c][k+1];
              nh[c]++;
              if (c + 1 < PW) begin
                nxt[c+1][nh[c+1]] = heap[c][k] & heap[c][k+1];
                nh[c+1]++;
              end
              k += 2;
            end
          end
          for (int r = 0; r < MAXH; r++) begin
            if (r >= k && r < hgt[c]) begin
              nxt[c][nh[c]] = heap[c][r];
              nh[c]++;
            end
          end
        end
        heap = nxt;
        hgt  = nh;
      end
    end

    row0 = '0;
    row1 = '0;
    for (int c = 0; c < PW; c++) begin
      row0[c] = heap[c][0];
      row1[c] = heap[c][1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sgn   <= 1'b0;
      s2_row0  <= '0;
      s2_row1  <= '0;
      out      <= '0;
    end else if (advance) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      if (in_valid) begin
        s1_a   <= in1;
        s1_b   <= in2;
        s1_sgn <= signed_mode;
      end
      if (vld_pipe[1]) begin
        s2_row0 <= row0;
        s2_row1 <= row1;
      end
      // A bubble reaching S3 leaves the last product on out.
      if (vld_pipe[2]) out <= KSA_nbits(s2_row0, s2_row1);
    end
  end
endmodule

// File: tb/tb_dadda_multiplier_pipelined.sv
// Directed plus random checks of dadda_multiplier_pipelined at WIDTH = 8 against an arithmetic model.
module tb_dadda_multiplier_pipelined;
  logic        clk, rst;
  logic [7:0]  in1, in2;
  logic        signed_mode, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] out;

  int checks = 0;
  int passed = 0;
  int fires  = 0;
  logic [15:0] q[$];

  dadda_multiplier_pipelined #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b, input logic sm);
    longint x, y;
    if (sm) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'(a);
      y = longint'(b);
    end
    return 16'(x * y);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: drive at negedge, score the output handshake, enqueue an accepted pair.
  task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic sm, input logic ordy, input logic [15:0] exp);
    in_valid = v; in1 = a; in2 = b; signed_mode = sm; out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      fires++;
      checks++;
      assert (q.size() != 0) passed++;
      else $error("FAIL unexpected_out: got %0h expected no output", out);
      if (q.size() != 0) chk("product", 32'(out), 32'(q.pop_front()));
    end
    if (v && in_ready) q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && q.size() > 0; n++) cycle(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 16'h0);
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rv, ro, rs;
    int         f0;
    rst = 1'b0; in1 = 8'd0; in2 = 8'd0; signed_mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Latency: accepted on edge 1, visible after edge 3, held after a trailing bubble
    in1 = 8'hFF; in2 = 8'hFF; signed_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    #1 chk("lat_e1_valid", 32'(out_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    #1 chk("lat_e2_valid", 32'(out_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    #1 chk("lat_e3_valid", 32'(out_valid), 32'd1);
    chk("lat_e3_out", 32'(out), 32'hFE01);
    @(posedge clk); @(negedge clk);
    #1 chk("bubble_valid", 32'(out_valid), 32'd0);
    chk("bubble_hold_out", 32'(out), 32'hFE01);

    // Directed corner products, back-to-back mode changes
    cycle(1'b1, 8'h80, 8'h80, 1'b1, 1'b1, 16'h4000);
    cycle(1'b1, 8'hFF, 8'h01, 1'b1, 1'b1, 16'hFFFF);
    cycle(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1, 16'h00FF);
    cycle(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 16'h0001);
    cycle(1'b1, 8'h80, 8'h7F, 1'b1, 1'b1, 16'hC080);
    drain();

    // Stream 0..9 x 3 with alternating mode
    f0 = fires;
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 8'(i), 8'd3, 1'(i % 2), 1'b1, ref_prod(8'(i), 8'd3, 1'(i % 2)));
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 16'h0);
    chk("stream_count", 32'(fires - f0), 32'd10);
    chk("stream_empty", 32'(q.size()), 32'd0);

    // Fill with out_ready low, stall 5 cycles, then release
    for (int i = 0; i < 4; i++) begin
      ra = 8'(8'd120 + 8'(i * 37)); rb = 8'(8'd200 - 8'(i * 11)); rs = 1'(i % 2);
      cycle(1'b1, ra, rb, rs, 1'b0, ref_prod(ra, rb, rs));
    end
    chk("fill_count", 32'(q.size()), 32'd3);
    for (int s = 0; s < 5; s++) begin
      in_valid = 1'b1; in1 = 8'($urandom); in2 = 8'($urandom); out_ready = 1'b0;
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out", 32'(out), 32'(q[0]));
      @(posedge clk); @(negedge clk);
    end
    drain();

    // Async reset mid-cycle with three transactions in flight
    for (int i = 0; i < 3; i++) begin
      ra = 8'(8'd90 + 8'(i)); rb = 8'(8'd170 + 8'(i));
      cycle(1'b1, ra, rb, 1'b0, 1'b1, ref_prod(ra, rb, 1'b0));
    end
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out", 32'(out), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    f0 = fires;
    cycle(1'b1, 8'd7, 8'd9, 1'b0, 1'b1, 16'd63);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 16'h0);
    chk("post_rst_fires", 32'(fires - f0), 32'd1);

    // Random traffic with random backpressure
    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom_range(0, 9) < 7);
      ro = ($urandom_range(0, 9) < 7);
      rs = 1'($urandom);
      ra = 8'($urandom); rb = 8'($urandom);
      cycle(rv, ra, rb, rs, ro, ref_prod(ra, rb, rs));
    end
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/dadda_multiplier_pipelined.md
DADDA_MULTIPLIER_PIPELINED -- requirements
Module: dadda_multiplier_pipelined

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 SHALL have clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have in1  input  WIDTH  multiplicand.
REQ-005 SHALL have in2  input  WIDTH  multiplier.
REQ-006 SHALL have signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-007 SHALL have in_valid  input  1  in1/in2/signed_mode valid this cycle.
REQ-008 SHALL have in_ready  output  1  block accepts an operand pair this cycle.
REQ-009 SHALL have out  output  2*WIDTH  product.
REQ-010 SHALL have out_valid  output  1  out holds a valid product.
REQ-011 SHALL have out_ready  input  1  consumer accepts out this cycle.

Function
REQ-012 SHALL form WIDTH x WIDTH partial products pp[i][j] = in1[j] & in2[i], column weight i+j.
REQ-013 SHALL, in signed mode, apply Baugh-Wooley correction: invert pp with exactly one of i,j = WIDTH-1; add constant 1 at column WIDTH and at column 2*WIDTH-1.
REQ-014 SHALL reduce columns with half/full adders per the Dadda height sequence 2,3,4,6,9,13,19,28..., reducing each stage to the next lower limit, down to 2 rows; generated from WIDTH, no hand-written per-width trees.
REQ-015 SHALL sum the final 2 rows with KSA_nbits.
REQ-016 SHALL drop carries beyond bit 2*WIDTH-1; out equals the exact product modulo 2^(2*WIDTH).
REQ-017 SHALL use 3 register stages: S1 = operands + mode; S2 = two reduced rows; S3 = out.
REQ-018 SHALL define advance = !out_valid | out_ready; in_ready = advance (combinational from out_ready and out_valid).
REQ-019 SHALL accept a pair on a rising edge where in_valid & in_ready.
REQ-020 SHALL, for a pair accepted at edge N with no stall, load S2 at N+1, S3 at N+2; out_valid = 1 after edge N+2.
REQ-021 SHALL, when advance = 0, hold all stage data and valid bits unchanged; out stable while out_valid & !out_ready.
REQ-022 SHALL carry a valid bit per stage; bubbles advance as invalid entries and are not collapsed.
REQ-023 SHALL sustain one product per cycle when in_valid and out_ready are held high.
REQ-024 SHALL deassert out_valid on an advance edge where S2 is invalid; out then holds its last value.
REQ-025 SHALL keep signed_mode attached to its own operand pair; per-transaction mode changes are legal back-to-back.
REQ-026 SHALL ignore in1/in2/signed_mode when in_valid = 0 or in_ready = 0.

Reset
REQ-027 SHALL, while rst = 1, immediately clear all stage valid bits, S1/S2 data and out to 0, independent of clk.
REQ-028 SHALL drive in_ready = 1 during and after reset.
REQ-029 SHALL discard in-flight transactions on reset; none reappear after rst falls.
REQ-030 SHALL accept a new pair on the first rising edge after rst deasserts.

Verification (WIDTH = 8)
REQ-031 Unsigned 255 x 255, out_ready = 1 -> out = 0xFE01, out_valid after 3rd edge from acceptance.
REQ-032 Signed -128 x -128 -> 0x4000. Signed -1 x 1 -> 0xFFFF. Unsigned 0xFF x 0x01 -> 0x00FF.
REQ-033 Stream 0..9 x 3, alternating signed_mode, out_ready = 1 -> 10 results in order, one per cycle, correct per mode.
REQ-034 Fill pipeline, then out_ready = 0 for 5 cycles -> in_ready = 0, out frozen, no loss or duplication; release -> remaining results in order.
REQ-035 Assert rst asynchronously mid-clock with 3 transactions in flight -> out_valid = 0 and out = 0 immediately, no stale results after release.
REQ-036 Random 10^5 pairs per mode at WIDTH = 4, 8, 13, 32, random in_valid/out_ready -> every out matches reference product, order preserved.
